// File: rtl/maze_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// maze_pkg: shared types, direction codes and coordinate helpers for the
//           maze solver. Rev 1.0
// ----------------------------------------------------------------------------
package maze_pkg;

  localparam int MAP_DIM = 16;
  localparam int COORD_W = $clog2(MAP_DIM) + 1;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_RIGHT = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_DOWN  = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_MARK   = 4'd1,
    S_PROBE  = 4'd2,
    S_CHECK  = 4'd3,
    S_ADV    = 4'd4,
    S_BACK   = 4'd5,
    S_DONE   = 4'd6,
    S_FAIL   = 4'd7,
    S_REPLAY = 4'd8
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  // Plain wrap-around arithmetic: stepping off the map lands on a coord with
  // bit 4 set, which the memory reports as a wall.
  function automatic coord_t neighbour(input coord_t c, input dir_t d);
    coord_t n;
    n = c;
    case (d)
      DIR_UP:    n.y = c.y - COORD_W'(1);
      DIR_RIGHT: n.x = c.x + COORD_W'(1);
      DIR_LEFT:  n.x = c.x - COORD_W'(1);
      default:   n.y = c.y + COORD_W'(1);
    endcase
    return n;
  endfunction

  // Codes are chosen so that inverting both bits reverses the direction.
  function automatic dir_t opposite(input dir_t d);
    return ~d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/path_stack.sv
`default_nettype none
// ----------------------------------------------------------------------------
// path_stack: DEPTH x 2-bit LIFO of taken moves with a random read port used
//             to replay the path bottom-first. Rev 1.0
// ----------------------------------------------------------------------------
module path_stack
  import maze_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  dir_t             push_dir,
  output dir_t             top_dir,
  input  logic [PTR_W-2:0] rd_idx,
  output dir_t             rd_dir,
  output logic [PTR_W-1:0] sp,
  output logic             full,
  output logic             empty
);

  localparam int AW = PTR_W - 1;

  dir_t          entries [DEPTH];
  logic [AW-1:0] top_ptr;

  assign full    = (sp == PTR_W'(DEPTH));
  assign empty   = (sp == '0);
  // Wraps correctly when sp == DEPTH because only the low bits are used.
  assign top_ptr = sp[AW-1:0] - AW'(1);
  assign top_dir = entries[top_ptr];
  assign rd_dir  = entries[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (clear) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + PTR_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !clear) begin
      entries[sp[AW-1:0]] <= push_dir;
    end
  end

endmodule
`default_nettype wire

// File: rtl/maze_solver_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// maze_solver_ctrl: backtracking DFS path-finder that masters the maze
//                   bit-memory and replays the found path. Rev 1.0
// ----------------------------------------------------------------------------
module maze_solver_ctrl
  import maze_pkg::*;
#(
  parameter int START_X = 0,
  parameter int START_Y = 0,
  parameter int GOAL_X  = 15,
  parameter int GOAL_Y  = 15,
  parameter int DEPTH   = 256,
  parameter int PTR_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Start,
  input  logic               Show,
  output logic [COORD_W-1:0] Xout,
  output logic [COORD_W-1:0] Yout,
  output logic               RD,
  output logic               WR,
  output logic               Dmem,
  input  logic               Dout,
  output logic               Done,
  output logic               Fail,
  output logic [1:0]         Move,
  output logic               MoveValid,
  output logic               PathEnd
);

  localparam int AW = PTR_W - 1;

  state_t             state, state_nxt;
  logic [COORD_W-1:0] x, x_nxt, y, y_nxt;
  dir_t               dir, dir_nxt;
  logic [PTR_W-1:0]   idx, idx_nxt;
  logic [PTR_W-1:0]   sp;
  coord_t             cur, nb, back, addr, last_addr;
  logic               push, pop, clear, full, empty, init;
  dir_t               top_dir, rd_dir;

  assign cur  = '{x: x, y: y};
  assign nb   = neighbour(cur, dir);
  assign back = neighbour(cur, opposite(top_dir));

  path_stack #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .push     (push),
    .pop      (pop),
    .push_dir (dir),
    .top_dir  (top_dir),
    .rd_idx   (idx[AW-1:0]),
    .rd_dir   (rd_dir),
    .sp       (sp),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      x         <= COORD_W'(START_X);
      y         <= COORD_W'(START_Y);
      dir       <= DIR_UP;
      idx       <= '0;
      last_addr <= '0;
    end else begin
      state     <= state_nxt;
      x         <= x_nxt;
      y         <= y_nxt;
      dir       <= dir_nxt;
      idx       <= idx_nxt;
      last_addr <= addr;
    end
  end

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    dir_nxt   = dir;
    idx_nxt   = idx;
    addr      = last_addr;
    RD        = 1'b0;
    WR        = 1'b0;
    Dmem      = 1'b0;
    Move      = 2'd0;
    MoveValid = 1'b0;
    PathEnd   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    init      = 1'b0;

    case (state)
      S_IDLE: begin
        if (Start) init = 1'b1;
      end
      S_MARK: begin
        WR   = 1'b1;
        Dmem = 1'b1;
        addr = cur;
        if (x == COORD_W'(GOAL_X) && y == COORD_W'(GOAL_Y)) begin
          state_nxt = S_DONE;
        end else begin
          dir_nxt   = DIR_UP;
          state_nxt = S_PROBE;
        end
      end
      S_PROBE: begin
        RD        = 1'b1;
        addr      = nb;
        state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (!Dout) begin
          state_nxt = S_ADV;
        end else if (dir != DIR_DOWN) begin
          dir_nxt   = dir + 2'd1;
          state_nxt = S_PROBE;
        end else begin
          state_nxt = S_BACK;
        end
      end
      S_ADV: begin
        if (full) begin
          state_nxt = S_FAIL;
        end else begin
          push      = 1'b1;
          x_nxt     = nb.x;
          y_nxt     = nb.y;
          state_nxt = S_MARK;
        end
      end
      S_BACK: begin
        if (empty) begin
          state_nxt = S_FAIL;
        end else begin
          // Returning to the parent resumes its scan after the direction
          // that led here; a popped DOWN exhausts the parent too.
          pop   = 1'b1;
          x_nxt = back.x;
          y_nxt = back.y;
          if (top_dir != DIR_DOWN) begin
            dir_nxt   = top_dir + 2'd1;
            state_nxt = S_PROBE;
          end
        end
      end
      S_DONE: begin
        if (Start) begin
          init = 1'b1;
        end else if (Show) begin
          idx_nxt   = '0;
          state_nxt = S_REPLAY;
        end
      end
      S_FAIL: begin
        if (Start) init = 1'b1;
      end
      S_REPLAY: begin
        if (idx == sp) begin
          PathEnd   = 1'b1;
          state_nxt = S_DONE;
        end else begin
          MoveValid = 1'b1;
          Move      = rd_dir;
          idx_nxt   = idx + PTR_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (init) begin
      x_nxt     = COORD_W'(START_X);
      y_nxt     = COORD_W'(START_Y);
      dir_nxt   = DIR_UP;
      state_nxt = S_MARK;
    end
  end

  assign clear = init;
  assign Xout  = addr.x;
  assign Yout  = addr.y;
  assign Done  = (state == S_DONE) || (state == S_REPLAY);
  assign Fail  = (state == S_FAIL);

endmodule
`default_nettype wire

// File: tb/tb_maze_solver_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_maze_solver_ctrl: scoreboard bench pairing three solver configurations
//                      with maze memory models. Rev 1.0
// ----------------------------------------------------------------------------
module tb_maze_solver_ctrl;
  import maze_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // a: default 256-deep, (0,0)->(15,15)
  logic       a_start, a_show, a_rd, a_wr, a_dmem, a_dout, a_done, a_fail, a_mv, a_pend;
  logic [4:0] a_x, a_y;
  logic [1:0] a_move;
  // b: start == goal == (5,5)
  logic       b_start, b_show, b_rd, b_wr, b_dmem, b_dout, b_done, b_fail, b_mv, b_pend;
  logic [4:0] b_x, b_y;
  logic [1:0] b_move;
  // c: 8-deep stack
  logic       c_start, c_show, c_rd, c_wr, c_dmem, c_dout, c_done, c_fail, c_mv, c_pend;
  logic [4:0] c_x, c_y;
  logic [1:0] c_move;

  logic [15:0] mem_a [16];
  logic [15:0] mem_c [16];
  int          q_a [$];
  int          q_b [$];
  int          c_wr_cnt = 0;

  assign b_dout = 1'b0;

  maze_solver_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .Start(a_start), .Show(a_show), .Xout(a_x), .Yout(a_y),
    .RD(a_rd), .WR(a_wr), .Dmem(a_dmem), .Dout(a_dout), .Done(a_done), .Fail(a_fail),
    .Move(a_move), .MoveValid(a_mv), .PathEnd(a_pend)
  );

  maze_solver_ctrl #(.START_X(5), .START_Y(5), .GOAL_X(5), .GOAL_Y(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .Start(b_start), .Show(b_show), .Xout(b_x), .Yout(b_y),
    .RD(b_rd), .WR(b_wr), .Dmem(b_dmem), .Dout(b_dout), .Done(b_done), .Fail(b_fail),
    .Move(b_move), .MoveValid(b_mv), .PathEnd(b_pend)
  );

  maze_solver_ctrl #(.DEPTH(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .Start(c_start), .Show(c_show), .Xout(c_x), .Yout(c_y),
    .RD(c_rd), .WR(c_wr), .Dmem(c_dmem), .Dout(c_dout), .Done(c_done), .Fail(c_fail),
    .Move(c_move), .MoveValid(c_mv), .PathEnd(c_pend)
  );

  // Memory models: registered read, out-of-range reads as wall
  always @(posedge clk) begin
    if (a_rd) a_dout <= (a_x[4] | a_y[4]) ? 1'b1 : mem_a[a_y[3:0]][a_x[3:0]];
    if (a_wr && !a_x[4] && !a_y[4]) mem_a[a_y[3:0]][a_x[3:0]] <= a_dmem;
    if (c_rd) c_dout <= (c_x[4] | c_y[4]) ? 1'b1 : mem_c[c_y[3:0]][c_x[3:0]];
    if (c_wr && !c_x[4] && !c_y[4]) mem_c[c_y[3:0]][c_x[3:0]] <= c_dmem;
    if (c_wr) c_wr_cnt <= c_wr_cnt + 1;
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Scoreboard monitors: 0..3 = move code, 4 = PathEnd
  always @(negedge clk) begin
    int got;
    if (a_mv || a_pend) begin
      got = a_pend ? 4 : int'(a_move);
      if (a_mv && a_pend) check("a_mv_pend_exclusive", 1, 0);
      if (q_a.size() == 0) check("a_unexpected_output", got, -1);
      else check("a_replay_step", got, q_a.pop_front());
    end
    if (b_mv || b_pend) begin
      got = b_pend ? 4 : int'(b_move);
      if (q_b.size() == 0) check("b_unexpected_output", got, -1);
      else check("b_replay_step", got, q_b.pop_front());
    end
    if (c_mv || c_pend) check("c_unexpected_output", 1, 0);
  end

  // Memory-port and status invariants
  always @(negedge clk) begin
    if (a_rd || a_wr) check("a_rd_wr_exclusive", int'(a_rd && a_wr), 0);
    if (a_wr)         check("a_wr_dmem", int'(a_dmem), 1);
    if (a_done || a_fail) check("a_done_fail_exclusive", int'(a_done && a_fail), 0);
    if (c_rd || c_wr) check("c_rd_wr_exclusive", int'(c_rd && c_wr), 0);
    if (c_wr)         check("c_wr_dmem", int'(c_dmem), 1);
    if (b_wr)         check("b_wr_dmem", int'(b_dmem), 1);
    if (b_rd)         check("b_no_read", 1, 0);
  end

  task automatic load_a(input logic [15:0] rows [16]);
    for (int r = 0; r < 16; r++) mem_a[r] <= rows[r];
    @(negedge clk);
  endtask

  task automatic pulse_a_start();
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic wait_a_end(input string name, input int budget);
    int n = 0;
    while (!(a_done || a_fail) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check({name, "_timeout"}, n, -1);
  endtask

  task automatic replay_a(input string name);
    int n = 0;
    a_show = 1'b1;
    @(negedge clk);
    a_show = 1'b0;
    while (q_a.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_queue_drained"}, q_a.size(), 0);
    @(negedge clk);
    check({name, "_done_after_replay"}, int'(a_done), 1);
  endtask

  // Boustrophedon DFS on an open map: even rows go right, odd rows left
  task automatic push_snake();
    for (int r = 0; r < 15; r++) begin
      for (int k = 0; k < 15; k++) q_a.push_back((r % 2 == 0) ? 1 : 2);
      q_a.push_back(3);
    end
    q_a.push_back(4);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_a"}, int'({a_x, a_y, a_rd, a_wr, a_dmem, a_done, a_fail, a_move, a_mv, a_pend}), 0);
    check({name, "_b"}, int'({b_x, b_y, b_rd, b_wr, b_dmem, b_done, b_fail, b_move, b_mv, b_pend}), 0);
    check({name, "_c"}, int'({c_x, c_y, c_rd, c_wr, c_dmem, c_done, c_fail, c_move, c_mv, c_pend}), 0);
  endtask

  initial begin
    logic [15:0] open_map [16];
    logic [15:0] row1_map [16];
    logic [15:0] cor_map  [16];
    int n;

    for (int r = 0; r < 16; r++) begin
      open_map[r] = 16'h0000;
      row1_map[r] = 16'h0000;
      cor_map[r]  = 16'hFFFB;
    end
    row1_map[1] = 16'hFFFF;
    cor_map[0]  = 16'hFFE0;
    cor_map[15] = 16'h0003;

    rst_n = 1'b0;
    {a_start, a_show, b_start, b_show, c_start, c_show} = '0;
    for (int r = 0; r < 16; r++) mem_c[r] = 16'h0000;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: open map
    load_a(open_map);
    push_snake();
    pulse_a_start();
    wait_a_end("t1", 20000);
    check("t1_done", int'(a_done), 1);
    check("t1_fail", int'(a_fail), 0);
    check("t1_sp", int'(dut_a.sp), 240);
    replay_a("t1");

    // 2: row 1 walled off
    load_a(row1_map);
    pulse_a_start();
    wait_a_end("t2", 20000);
    check("t2_fail", int'(a_fail), 1);
    check("t2_done", int'(a_done), 0);
    check("t2_sp", int'(dut_a.sp), 0);
    a_show = 1'b1;
    @(negedge clk);
    a_show = 1'b0;
    repeat (3) @(negedge clk);
    check("t2_fail_held", int'(a_fail), 1);

    // 3: dead end at (3,0)-(4,0) forces backtrack into column 2
    load_a(cor_map);
    q_a.push_back(1);
    q_a.push_back(1);
    for (int k = 0; k < 15; k++) q_a.push_back(3);
    for (int k = 0; k < 13; k++) q_a.push_back(1);
    q_a.push_back(4);
    pulse_a_start();
    wait_a_end("t3", 20000);
    check("t3_done", int'(a_done), 1);
    check("t3_fail", int'(a_fail), 0);
    replay_a("t3");

    // 4: start == goal
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    check("t4_mark_wr", int'(b_wr), 1);
    check("t4_mark_xy", int'({b_x, b_y}), int'({5'd5, 5'd5}));
    check("t4_done_early", int'(b_done), 0);
    @(negedge clk);
    check("t4_done", int'(b_done), 1);
    q_b.push_back(4);
    b_show = 1'b1;
    @(negedge clk);
    b_show = 1'b0;
    @(negedge clk);
    check("t4_queue_drained", q_b.size(), 0);
    check("t4_done_held", int'(b_done), 1);
    check("t4_pathend_pulse", int'(b_pend), 0);

    // 5: 8-deep stack overflows on the ninth push
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    n = 0;
    while (!(c_fail || c_done) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("t5_timeout", n, -1);
    check("t5_fail", int'(c_fail), 1);
    check("t5_done", int'(c_done), 0);
    check("t5_wr_count", c_wr_cnt, 9);
    check("t5_sp", int'(dut_c.sp), 8);

    // 6: reset while in CHECK, then solve a fresh map
    load_a(open_map);
    pulse_a_start();
    n = 0;
    while (n < 5) begin
      @(negedge clk);
      if (a_rd) n++;
      if (a_done || a_fail) n = 99;
    end
    check("t6_reached_probe", n, 5);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("t6_reset_outputs");
    check("t6_state_idle", int'(dut_a.state), int'(S_IDLE));
    rst_n = 1'b1;
    load_a(open_map);
    push_snake();
    pulse_a_start();
    wait_a_end("t6", 20000);
    check("t6_done", int'(a_done), 1);
    replay_a("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
